// File: rtl/booth_pp_if.sv
// Operand/partial-product bus for the Booth partial-product generator.
// A beat transfers on any rising edge where valid and ready are both high; valid never waits on ready.
interface booth_pp_if #(
  parameter int WIDTH = 8
);
  localparam int NUM_PP = WIDTH / 2;
  localparam int PPW    = WIDTH + 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        x_i;
  logic [WIDTH-1:0]        y_i;
  logic                    out_valid;
  logic                    out_ready;
  logic [NUM_PP*PPW-1:0]   pp_o;
  logic [NUM_PP-1:0]       sign_o;

  modport master (
    output in_valid, x_i, y_i, out_ready,
    input  in_ready, out_valid, pp_o, sign_o
  );

  modport slave (
    input  in_valid, x_i, y_i, out_ready,
    output in_ready, out_valid, pp_o, sign_o
  );
endinterface

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth recoder feeding a 2-entry FIFO of {partial products, negate bits}.
// The FIFO occupancy is a small three-process FSM whose state is exported on dbg_state_o.
module booth_pp_gen #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  booth_pp_if.slave  bus,
  output logic [1:0] dbg_state_o
);
  localparam int NUM_PP = WIDTH / 2;
  localparam int PPW    = WIDTH + 1;
  localparam int EW     = NUM_PP * PPW + NUM_PP;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]       mem_q [2];

  logic                accept;
  logic                pop;
  logic [WIDTH:0]      y_ext;
  logic [PPW-1:0]      x_one;
  logic [PPW-1:0]      x_two;
  logic [2:0]          trip;
  logic [PPW-1:0]      mag;
  logic                neg;
  logic [NUM_PP*PPW-1:0] enc_pp;
  logic [NUM_PP-1:0]   enc_sign;
  logic [EW-1:0]       head;

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = bus.out_valid & bus.out_ready;

  // y_ext[0] is the implicit y[-1]=0, so row k looks at y_ext[2k+2:2k].
  assign y_ext = {bus.y_i, 1'b0};
  assign x_one = {bus.x_i[WIDTH-1], bus.x_i};
  assign x_two = {bus.x_i, 1'b0};

  always_comb begin
    enc_pp   = '0;
    enc_sign = '0;
    trip     = '0;
    mag      = '0;
    neg      = 1'b0;
    for (int k = 0; k < NUM_PP; k++) begin
      trip = y_ext[2*k +: 3];
      mag  = '0;
      neg  = 1'b0;
      case (trip)
        3'b001, 3'b010: mag = x_one;
        3'b101, 3'b110: begin mag = x_one; neg = 1'b1; end
        3'b011:         mag = x_two;
        3'b100:         begin mag = x_two; neg = 1'b1; end
        default:        mag = '0;
      endcase
      enc_pp[k*PPW +: PPW] = neg ? ~mag : mag;
      enc_sign[k]          = neg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      // Accept and pop never target the same slot: in ONE the pointers differ.
      if (accept) mem_q[wr_ptr_q] <= {enc_pp, enc_sign};
      if (pop)    mem_q[rd_ptr_q] <= '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q ^ accept;
    rd_ptr_d = rd_ptr_q ^ pop;
    case (state_q)
      EMPTY:   if (accept) state_d = ONE;
      ONE: begin
        if (accept && !pop)      state_d = FULL;
        else if (pop && !accept) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    bus.in_ready  = !reset && (state_q != FULL);
    bus.out_valid = !reset && (state_q != EMPTY);
    head          = bus.out_valid ? mem_q[rd_ptr_q] : '0;
    bus.pp_o      = head[EW-1:NUM_PP];
    bus.sign_o    = head[NUM_PP-1:0];
    dbg_state_o   = state_q;
  end
endmodule
